// File: rtl/class_hvec_assoc_search.sv
// Associative search over stored class hypervectors.
// Loads a query, scans every class by Hamming distance, reports the closest.
module class_hvec_assoc_search #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DI_PARALLEL_W_BITS-1:0]          q_frame_in,
  input  logic                                   q_valid,
  output logic                                   q_ready,
  output logic [$clog2(N_CLASSES)-1:0]           frame_id,
  output logic [$clog2(N_FRAMES)-1:0]            frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0]          class_vec_in,
  output logic [$clog2(N_CLASSES)-1:0]           res_class,
  output logic [$clog2(DI_PARALLEL_W_BITS*N_FRAMES+1)-1:0] res_dist,
  output logic                                   res_valid,
  input  logic                                   res_ready
);

  localparam int W  = DI_PARALLEL_W_BITS;
  localparam int D  = W * N_FRAMES;
  localparam int CW = $clog2(N_CLASSES);
  localparam int FW = $clog2(N_FRAMES);
  localparam int DW = $clog2(D + 1);

  localparam logic [CW-1:0] LASTC = CW'(N_CLASSES - 1);
  localparam logic [FW-1:0] LASTF = FW'(N_FRAMES - 1);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;

  logic [1:0]    state;
  logic [FW-1:0] ld_idx;
  logic [CW-1:0] cls;
  logic [FW-1:0] frm;
  logic [DW-1:0] acc;
  logic [CW-1:0] best_cls;
  logic [DW-1:0] best_dist;
  logic [W-1:0]  qbuf [N_FRAMES];

  logic [DW-1:0] d;
  logic          take;
  logic          q_acc;

  function automatic logic [DW-1:0] popcnt(
    input logic [W-1:0] v
  );
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s = s + DW'(v[i]);
    end
    return s;
  endfunction

  assign q_ready     = (state == LOAD);
  assign res_valid   = (state == RESULT);
  assign q_acc       = q_ready && q_valid;
  assign frame_id    = (state == COMPUTE) ? cls : '0;
  assign frame_index = (state == COMPUTE) ? frm : '0;

  // Running distance and best-so-far selection (ties keep lower class)
  always_comb begin
    d    = acc + popcnt(qbuf[frm] ^ class_vec_in);
    take = (cls == '0) || (d < best_dist);
  end

  // Query buffer capture, no reset needed: slots are rewritten per query
  always_ff @(posedge clk) begin
    if (!rst && q_acc) begin
      qbuf[ld_idx] <= q_frame_in;
    end
  end

  // Control FSM, distance accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      ld_idx    <= '0;
      cls       <= '0;
      frm       <= '0;
      acc       <= '0;
      best_cls  <= '0;
      best_dist <= '0;
      res_class <= '0;
      res_dist  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (q_valid) begin
            if (ld_idx == LASTF) begin
              ld_idx <= '0;
              cls    <= '0;
              frm    <= '0;
              acc    <= '0;
              state  <= COMPUTE;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (frm != LASTF) begin
            acc <= d;
            frm <= frm + 1'b1;
          end else begin
            acc <= '0;
            frm <= '0;
            if (take) begin
              best_dist <= d;
              best_cls  <= cls;
            end
            if (cls == LASTC) begin
              res_class <= take ? cls : best_cls;
              res_dist  <= take ? d : best_dist;
              state     <= RESULT;
            end else begin
              cls <= cls + 1'b1;
            end
          end
        end
        RESULT: begin
          if (res_ready) begin
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_class_hvec_assoc_search.sv
// Directed bench for class_hvec_assoc_search.
// Bench-side ROM model, hand-derived expected class/distance/latency.
module tb_class_hvec_assoc_search;

  logic        clk;
  logic        rst;
  logic [63:0] q_frame_in;
  logic        q_valid;
  logic        q_ready;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic [2:0]  res_class;
  logic [7:0]  res_dist;
  logic        res_valid;
  logic        res_ready;
  logic        tie_mode;

  int errs;
  int checks;

  class_hvec_assoc_search dut (
    .clk          (clk),
    .rst          (rst),
    .q_frame_in   (q_frame_in),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .res_class    (res_class),
    .res_dist     (res_dist),
    .res_valid    (res_valid),
    .res_ready    (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct per-class patterns: odd multiplier keeps classes apart per frame
  function automatic logic [63:0] rom(
    input logic [2:0] c,
    input logic [1:0] f
  );
    logic [63:0] k;
    logic [63:0] j;
    k = 64'h9E37_79B9_7F4A_7C15;
    j = 64'h0F0F_1234_5678_9ABD;
    return 64'hA5A5_5A5A_C3C3_3C3C ^ (({61'b0, c} * k) + ({62'b0, f} * j));
  endfunction

  // Stub ROM, optionally aliasing class 6 onto class 1
  always_comb begin
    if (tie_mode && frame_id == 3'd6)
      class_vec_in = rom(3'd1, frame_index);
    else
      class_vec_in = rom(frame_id, frame_index);
  end

  task automatic load(
    input logic [63:0] f0,
    input logic [63:0] f1,
    input logic [63:0] f2,
    input int          gap
  );
    logic [63:0] fr [3];
    fr[0] = f0;
    fr[1] = f1;
    fr[2] = f2;
    for (int i = 0; i < 3; i++) begin
      repeat (gap) begin
        q_valid = 1'b0;
        @(negedge clk);
      end
      q_valid    = 1'b1;
      q_frame_in = fr[i];
      @(negedge clk);
    end
    q_valid = 1'b0;
  endtask

  task automatic load_cls(
    input logic [2:0] c,
    input logic       flip,
    input int         gap
  );
    logic [63:0] f1;
    f1 = rom(c, 2'd1) ^ {63'b0, flip};
    load(rom(c, 2'd0), f1, rom(c, 2'd2), gap);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errs++;
      $display("FAIL res_timeout: waited %0d cycles, need res_valid", n);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    q_valid   = 1'b0;
    res_ready = 1'b1;
    q_frame_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (q_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_q_ready: got %b need 1", q_ready);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_res_valid: got %b need 0", res_valid);
    end
    checks++;
    if (res_class !== 3'd0 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL rst_res: got %0d/%0d need 0/0", res_class, res_dist);
    end
    checks++;
    if (frame_id !== 3'd0 || frame_index !== 2'd0) begin
      errs++;
      $display("FAIL rst_sel: got %0d/%0d need 0/0", frame_id, frame_index);
    end
  endtask

  task automatic test_exact;
    int n;
    res_ready = 1'b1;
    load_cls(3'd3, 1'b0, 0);
    wait_res(n);
    checks++;
    if (n != 24) begin
      errs++;
      $display("FAIL exact_latency: got %0d need 24", n);
    end
    checks++;
    if (res_class !== 3'd3 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL exact_res: got %0d/%0d need 3/0", res_class, res_dist);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || q_ready !== 1'b1) begin
      errs++;
      $display("FAIL exact_pulse: got rv=%b qr=%b need 0/1", res_valid, q_ready);
    end
  endtask

  task automatic test_flip(input int gap);
    int n;
    load_cls(3'd2, 1'b1, gap);
    wait_res(n);
    checks++;
    if (n != 24) begin
      errs++;
      $display("FAIL flip_latency gap=%0d: got %0d need 24", gap, n);
    end
    checks++;
    if (res_class !== 3'd2 || res_dist !== 8'd1) begin
      errs++;
      $display("FAIL flip_res gap=%0d: got %0d/%0d need 2/1", gap, res_class, res_dist);
    end
    @(negedge clk);
  endtask

  task automatic test_tie;
    int n;
    tie_mode = 1'b1;
    load_cls(3'd1, 1'b0, 0);
    wait_res(n);
    checks++;
    if (res_class !== 3'd1 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL tie_res: got %0d/%0d need 1/0", res_class, res_dist);
    end
    @(negedge clk);
    tie_mode = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    res_ready = 1'b0;
    load_cls(3'd6, 1'b0, 0);
    wait_res(n);
    for (int i = 0; i < 10; i++) begin
      q_valid    = 1'b1;
      q_frame_in = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_class !== 3'd6 ||
          res_dist !== 8'd0 || q_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold[%0d]: got rv=%b %0d/%0d qr=%b need 1 6/0 0",
                 i, res_valid, res_class, res_dist, q_ready);
      end
    end
    q_valid   = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || q_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_release: got rv=%b qr=%b need 0/1", res_valid, q_ready);
    end
    checks++;
    if (res_class !== 3'd6 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL bp_retain: got %0d/%0d need 6/0", res_class, res_dist);
    end
  endtask

  task automatic test_reset_mid_compute;
    int n;
    load_cls(3'd5, 1'b0, 0);
    repeat (10) @(negedge clk);
    checks++;
    if (frame_id !== 3'd3 || frame_index !== 2'd1 || q_ready !== 1'b0) begin
      errs++;
      $display("FAIL compute_sel: got %0d/%0d qr=%b need 3/1 0",
               frame_id, frame_index, q_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || q_ready !== 1'b1 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL midc_rst: got rv=%b qr=%b d=%0d need 0/1/0",
               res_valid, q_ready, res_dist);
    end
    load_cls(3'd7, 1'b0, 0);
    wait_res(n);
    checks++;
    if (n != 24) begin
      errs++;
      $display("FAIL midc_latency: got %0d need 24", n);
    end
    checks++;
    if (res_class !== 3'd7 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL midc_res: got %0d/%0d need 7/0", res_class, res_dist);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    int n;
    q_valid    = 1'b1;
    q_frame_in = ~rom(3'd4, 2'd0);
    @(negedge clk);
    q_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_cls(3'd4, 1'b0, 0);
    wait_res(n);
    checks++;
    if (n != 24 || res_class !== 3'd4 || res_dist !== 8'd0) begin
      errs++;
      $display("FAIL midl_res: got n=%0d %0d/%0d need 24 4/0",
               n, res_class, res_dist);
    end
    @(negedge clk);
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    tie_mode = 1'b0;
    test_reset();
    test_exact();
    test_flip(0);
    test_tie();
    test_backpressure();
    test_flip(2);
    test_reset_mid_compute();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/class_hvec_assoc_search.md
CLASS_HVEC_ASSOC_SEARCH -- requirements
Module: class_hvec_assoc_search

Interface
REQ-001 SHALL have parameter DI_PARALLEL_W_BITS, default 64: frame width in bits.
REQ-002 SHALL have parameter N_CLASSES, default 8: number of stored class hypervectors.
REQ-003 SHALL have parameter N_FRAMES, default 3: frames per hypervector (D = 192 at defaults).
REQ-004 SHALL have ports as follows; one clock, reset synchronous and active-high:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- q_frame_in  input  DI_PARALLEL_W_BITS  query hypervector frame.
- q_valid  input  1  q_frame_in valid.
- q_ready  output  1  block accepts a query frame.
- frame_id  output  clog2(N_CLASSES)  class select to the class-vector ROM.
- frame_index  output  clog2(N_FRAMES)  frame select to the ROM.
- class_vec_in  input  DI_PARALLEL_W_BITS  ROM data, combinational from frame_id/frame_index.
- res_class  output  clog2(N_CLASSES)  predicted class.
- res_dist  output  clog2(D+1)  Hamming distance of predicted class.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumed.

Function
REQ-005 SHALL implement three states: LOAD, COMPUTE, RESULT.
REQ-006 In LOAD, q_ready SHALL be 1; each cycle with q_valid&&q_ready SHALL store q_frame_in into query buffer slot ld_idx, then increment ld_idx.
REQ-007 Query frames SHALL be accepted in order 0..N_FRAMES-1; gaps in q_valid SHALL only stall loading.
REQ-008 The accept of frame N_FRAMES-1 SHALL move to COMPUTE with cls=0, frm=0, acc=0, ld_idx=0.
REQ-009 In COMPUTE, frame_id SHALL equal cls and frame_index SHALL equal frm; in all other states both SHALL be 0.
REQ-010 Each COMPUTE cycle SHALL form d = acc + popcount(qbuf[frm] XOR class_vec_in), widths per REQ-004, no overflow possible.
REQ-011 If frm < N_FRAMES-1: acc<=d, frm<=frm+1.
REQ-012 If frm == N_FRAMES-1: best_dist<=d and best_cls<=cls when cls==0 or d < best_dist (strict; ties keep lower class index); acc<=0, frm<=0.
REQ-013 At frm==N_FRAMES-1 and cls==N_CLASSES-1 SHALL move to RESULT; otherwise cls<=cls+1.
REQ-014 COMPUTE SHALL take exactly N_CLASSES*N_FRAMES cycles (24 at defaults); last query accept at cycle T -> res_valid at T+N_CLASSES*N_FRAMES+1.
REQ-015 In RESULT, res_valid SHALL be 1 and res_class=best_cls, res_dist=best_dist, held stable until res_valid&&res_ready.
REQ-016 The handshake res_valid&&res_ready SHALL return to LOAD next cycle; res_valid SHALL drop to 0.
REQ-017 q_ready SHALL be 0 in COMPUTE and RESULT; q_valid there SHALL be ignored.
REQ-018 res_class/res_dist SHALL retain their last values outside RESULT; only res_valid qualifies them.

Reset
REQ-019 rst=1 at a clock edge SHALL force LOAD, ld_idx=0, cls=0, frm=0, acc=0, best_cls=0, best_dist=0, res_class=0, res_dist=0, res_valid=0; q_ready=1 the cycle after rst deasserts.
REQ-020 Reset in any state, including mid-COMPUTE or mid-LOAD, SHALL discard partial query and partial distances; the next query SHALL start at frame 0.

Verification
REQ-021 Query = ROM class 3 frames 0..2 exactly, res_ready=1 -> res_class=3, res_dist=0, res_valid at T+25, one cycle wide.
REQ-022 Query = ROM class 2 frames with bit 0 of frame 1 flipped -> res_class=2, res_dist=1.
REQ-023 Stub ROM with classes 1 and 6 identical, query equal to them -> res_class=1 (tie rule), res_dist=0.
REQ-024 res_ready held 0 for 10 cycles in RESULT -> res_valid, res_class, res_dist stable, q_ready=0; q_valid pulses ignored; after res_ready=1, q_ready=1 next cycle.
REQ-025 q_valid with 2-cycle gaps between frames -> same result as back-to-back loading; only load time differs.
REQ-026 rst asserted at COMPUTE cycle 10, then fresh class-7 query -> res_valid stays 0 until new result; res_class=7, res_dist=0.
